// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: runs 32-bit NIC word requests on a 16-bit async SRAM as LO then HI half-word cycles
// Ports:
//   i_clk, i_reset                 single clock; asynchronous active-high reset
//   i_ram_address                  NIC word address
//   i_ram_byteenable_n             active-low byte enables, bit i = byte i
//   i_ram_chipselect               request qualifier
//   i_ram_writedata                write data
//   i_ram_read_n, i_ram_write_n    active-low read / write strobes (both low = write)
//   o_ram_readdata                 read data, valid with o_ram_readdatavalid
//   o_ram_readdatavalid            one-cycle pulse per accepted read
//   o_ram_waitrequest              high while an access is in flight
//   o_sram_addr                    {word address, half}; half 0 = LO
//   io_sram_dq                     SRAM data bus
//   o_sram_lb_n .. o_sram_we_n     active-low SRAM byte lanes, chip, output and write enables
module ext_sram_ctrl #(
    parameter int RAM_ADDR_WIDTH  = 20,
    parameter int SRAM_ADDR_WIDTH = RAM_ADDR_WIDTH + 1,
    parameter int WAIT_CYCLES     = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [RAM_ADDR_WIDTH-1:0]  i_ram_address,
    input  logic [3:0]                 i_ram_byteenable_n,
    input  logic                       i_ram_chipselect,
    input  logic [31:0]                i_ram_writedata,
    input  logic                       i_ram_read_n,
    input  logic                       i_ram_write_n,
    output logic [31:0]                o_ram_readdata,
    output logic                       o_ram_readdatavalid,
    output logic                       o_ram_waitrequest,
    output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
    inout  wire  [15:0]                io_sram_dq,
    output logic                       o_sram_lb_n,
    output logic                       o_sram_ub_n,
    output logic                       o_sram_ce_n,
    output logic                       o_sram_oe_n,
    output logic                       o_sram_we_n
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    // phase counter runs 0..WAIT_CYCLES; the last count is the data-hold / bus-turnaround cycle
    localparam logic [3:0] LAST   = 4'(WAIT_CYCLES);
    localparam logic [3:0] SAMPLE = 4'(WAIT_CYCLES - 1);
    state_t                    r_state, w_next;
    logic [3:0]                r_cnt;
    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wdata;
    logic [3:0]                r_be_n;
    logic                      r_wr;
    logic [15:0]               r_lo, r_hi;
    logic [31:0]               r_readdata;
    logic                      r_rvalid;
    logic                      w_req, w_last, w_drive, w_hi;
    logic [15:0]               w_dout;
    assign w_req  = i_ram_chipselect & (~i_ram_read_n | ~i_ram_write_n);
    assign w_last = r_cnt == LAST;
    assign w_hi   = r_state == HI;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end
    // next state and SRAM pins, all decoded from registered state so reset idles the pins at once
    always_comb begin
        w_next            = r_state;
        o_ram_waitrequest = r_state != IDLE;
        o_sram_ce_n       = r_state == IDLE;
        o_sram_addr       = SRAM_ADDR_WIDTH'({r_addr, w_hi});
        o_sram_lb_n       = 1'b1;
        o_sram_ub_n       = 1'b1;
        o_sram_oe_n       = 1'b1;
        o_sram_we_n       = 1'b1;
        w_drive           = 1'b0;
        w_dout            = w_hi ? r_wdata[31:16] : r_wdata[15:0];
        // write halves with both byte enables off are skipped entirely
        if (r_state == IDLE && w_req)
            w_next = i_ram_write_n ? LO :
                     (&i_ram_byteenable_n[1:0]) ? ((&i_ram_byteenable_n[3:2]) ? IDLE : HI) : LO;
        else if (r_state == LO && w_last)
            w_next = (r_wr && &r_be_n[3:2]) ? IDLE : HI;
        else if (w_hi && w_last)
            w_next = IDLE;
        if (r_state != IDLE) begin
            o_sram_lb_n = r_wr & (w_hi ? r_be_n[2] : r_be_n[0]);
            o_sram_ub_n = r_wr & (w_hi ? r_be_n[3] : r_be_n[1]);
            o_sram_oe_n = r_wr | w_last;
            o_sram_we_n = ~r_wr | w_last;
            w_drive     = r_wr;
        end
    end
    assign io_sram_dq          = w_drive ? w_dout : 16'hzzzz;
    assign o_ram_readdata      = r_readdata;
    assign o_ram_readdatavalid = r_rvalid;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be_n     <= '1;
            r_wr       <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_readdata <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_cnt    <= (r_state == IDLE || w_last) ? 4'd0 : r_cnt + 4'd1;
            r_rvalid <= w_hi && w_last && !r_wr;
            if (r_state == IDLE && w_req) begin
                r_addr  <= i_ram_address;
                r_wdata <= i_ram_writedata;
                r_be_n  <= i_ram_byteenable_n;
                r_wr    <= ~i_ram_write_n;
            end
            // sample on the last oe-low cycle, one cycle before turnaround
            if (r_state != IDLE && !r_wr && r_cnt == SAMPLE) begin
                if (w_hi) r_hi <= io_sram_dq;
                else      r_lo <= io_sram_dq;
            end
            if (w_hi && w_last && !r_wr) r_readdata <= {r_hi, r_lo};
        end
    end
endmodule

// File: tb/tb_ext_sram_ctrl.sv
// tb_ext_sram_ctrl: scoreboard bench for ext_sram_ctrl at WAIT_CYCLES 1 and 3 with an async SRAM model
module tb_ext_sram_ctrl;
    typedef struct { logic [31:0] d; int due; } exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic        rst[2], cs[2], rdn[2], wrn[2];
    logic [19:0] ad[2];
    logic [3:0]  be[2];
    logic [31:0] wd[2], rdata[2];
    logic        rvalid[2], wreq[2];
    logic [20:0] sa[2];
    logic        lb_n[2], ub_n[2], ce_n[2], oe_n[2], we_n[2];
    wire  [15:0] dqv[2];
    logic [15:0] smem[2][256];
    logic [31:0] rm[2][128];
    exp_t        exp_q[2][$];
    int          vec = 0, err = 0, exp_busy = 0;
    int          ce_cnt[2];
    logic        last_lb[2], last_ub[2], last_half[2];
    for (genvar g = 0; g < 2; g++) begin : g_i
        wire [15:0] dq;
        ext_sram_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .i_clk(clk), .i_reset(rst[g]), .i_ram_address(ad[g]), .i_ram_byteenable_n(be[g]),
            .i_ram_chipselect(cs[g]), .i_ram_writedata(wd[g]), .i_ram_read_n(rdn[g]),
            .i_ram_write_n(wrn[g]), .o_ram_readdata(rdata[g]), .o_ram_readdatavalid(rvalid[g]),
            .o_ram_waitrequest(wreq[g]), .o_sram_addr(sa[g]), .io_sram_dq(dq),
            .o_sram_lb_n(lb_n[g]), .o_sram_ub_n(ub_n[g]), .o_sram_ce_n(ce_n[g]),
            .o_sram_oe_n(oe_n[g]), .o_sram_we_n(we_n[g]));
        // async SRAM read: data follows address while chip and output enables are low
        assign dq = (!ce_n[g] && !oe_n[g]) ? smem[g][sa[g][7:0]] : 16'hzzzz;
        assign dqv[g] = dq;
    end
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        vec++;
        if (act != want) begin
            err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endfunction
    // SRAM write capture and read-response scoreboard, one pass per falling edge
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!ce_n[i]) ce_cnt[i]++;
                if (!ce_n[i] && !we_n[i]) begin
                    chk("oe_high_during_write", 32'(oe_n[i]), 1);
                    chk("sram_addr_range", 32'(sa[i][20:8]), 0);
                    if (!lb_n[i]) smem[i][sa[i][7:0]][7:0]  = dqv[i][7:0];
                    if (!ub_n[i]) smem[i][sa[i][7:0]][15:8] = dqv[i][15:8];
                    last_lb[i]   = lb_n[i];
                    last_ub[i]   = ub_n[i];
                    last_half[i] = sa[i][0];
                end
                if (rvalid[i]) begin
                    if (exp_q[i].size() == 0) chk("spurious_valid", 32'(rvalid[i]), 0);
                    else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("rdata_%0d", i), rdata[i], e.d);
                        chk($sformatf("valid_cycle_%0d", i), cyc, e.due);
                    end
                end else if (exp_q[i].size() > 0 && cyc > exp_q[i][0].due) begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("valid_missing_%0d", i), cyc, e.due);
                end
            end
        end
    endtask
    // drive one request and hold it until accepted; busy = cycles waitrequest held it off
    task automatic issue(input int n, input bit rd, input bit wr, input int a,
                         input logic [3:0] b, input logic [31:0] d);
        int   busy = 0;
        int   p = n ? 4 : 2;
        exp_t e;
        ad[n] = 20'(a); be[n] = b; wd[n] = d; rdn[n] = !rd; wrn[n] = !wr; cs[n] = 1'b1;
        @(negedge clk);
        while (wreq[n] && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        chk($sformatf("busy_%0d", n), busy, exp_busy);
        if (wr) begin
            for (int k = 0; k < 4; k++) if (!b[k]) rm[n][a][8*k+:8] = d[8*k+:8];
            exp_busy = p * (int'(b[1:0] != 2'b11) + int'(b[3:2] != 2'b11));
        end else begin
            e.d   = rm[n][a];
            e.due = cyc + 2 * p + 1;
            exp_q[n].push_back(e);
            exp_busy = 2 * p;
        end
        @(posedge clk);
        #1;
        cs[n] = 1'b0; rdn[n] = 1'b1; wrn[n] = 1'b1;
    endtask
    task automatic idle(input int n);
        int t = 0;
        @(negedge clk);
        while (wreq[n] && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk("idle_reached", 32'(wreq[n]), 0);
        exp_busy = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input int n);
        int          p = n ? 4 : 2;
        int          ce0, a, r;
        logic [3:0]  b;
        exp_busy = 0;
        issue(n, 0, 1, 'h10, 4'h0, 32'h12345678);
        issue(n, 1, 0, 'h10, 4'h0, 0);
        chk("sram_0x20", 32'(smem[n][8'h20]), 32'h5678);
        chk("sram_0x21", 32'(smem[n][8'h21]), 32'h1234);
        issue(n, 0, 1, 'h30, 4'h0, 32'hFFFFFFFF);
        issue(n, 0, 1, 'h30, 4'b1100, 32'hAAAABBBB);
        issue(n, 1, 0, 'h30, 4'h0, 0);
        issue(n, 0, 1, 'h30, 4'b1011, 32'h00CC0000);
        issue(n, 1, 0, 'h30, 4'h0, 0);
        chk("hi_only_lb_n", 32'(last_lb[n]), 0);
        chk("hi_only_ub_n", 32'(last_ub[n]), 1);
        chk("hi_only_half", 32'(last_half[n]), 1);
        for (int k = 0; k < 4; k++) issue(n, 0, 1, 'h40 + k, 4'h0, $urandom);
        for (int k = 0; k < 4; k++) issue(n, 1, 0, 'h40 + k, 4'h0, 0);
        issue(n, 1, 1, 'h50, 4'h0, 32'hCAFEF00D);
        issue(n, 1, 0, 'h50, 4'h0, 0);
        idle(n);
        ce0 = ce_cnt[n];
        issue(n, 0, 1, 'h50, 4'hF, 32'h0);
        issue(n, 1, 0, 'h50, 4'h0, 0);
        chk("be1111_no_ce", ce_cnt[n], ce0);
        issue(n, 0, 1, 'h60, 4'h0, $urandom);
        idle(n);
        issue(n, 1, 0, 'h60, 4'h0, 0);
        repeat (p) @(posedge clk);
        @(negedge clk);
        chk("in_hi_phase", {ce_n[n], sa[n][0]}, 2'b01);
        rst[n] = 1'b1;
        void'(exp_q[n].pop_back());
        #1;
        chk("rst_mid_pins", {lb_n[n], ub_n[n], ce_n[n], oe_n[n], we_n[n]}, 5'h1f);
        chk("rst_mid_wreq", 32'(wreq[n]), 0);
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid[n]), 0);
        rst[n] = 1'b0;
        idle(n);
        issue(n, 1, 0, 'h60, 4'h0, 0);
        for (int k = 0; k < 40; k++) begin
            a = $urandom_range(0, 127);
            r = $urandom_range(0, 2);
            b = 4'($urandom);
            if (r == 0) issue(n, 1, 0, a, b, 0);
            else        issue(n, 0, 1, a, b, $urandom);
        end
        idle(n);
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cs[i] = 1'b0; rdn[i] = 1'b1; wrn[i] = 1'b1;
            ad[i] = '0; be[i] = 4'hF; wd[i] = '0; ce_cnt[i] = 0;
            last_lb[i] = 1'b1; last_ub[i] = 1'b1; last_half[i] = 1'b0;
            for (int j = 0; j < 256; j++) smem[i][j] = '0;
            for (int j = 0; j < 128; j++) rm[i][j] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_wreq", 32'(wreq[i]), 0);
            chk("rst_rvalid", 32'(rvalid[i]), 0);
            chk("rst_rdata", rdata[i], 0);
            chk("rst_addr", 32'(sa[i]), 0);
            chk("rst_pins", {lb_n[i], ub_n[i], ce_n[i], oe_n[i], we_n[i]}, 5'h1f);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;
        run(0);
        run(1);
        for (int t = 0; t < 100 && (exp_q[0].size() + exp_q[1].size()) > 0; t++) @(negedge clk);
        chk("queue_drained", exp_q[0].size() + exp_q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
